// File: rtl/exec_cc_controller_pkg.sv
// Shared constants for the execute-stage condition-code controller:
// instruction codes, status codes, condition function codes and CC bit positions.
package exec_cc_controller_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Pipeline status codes; any other encoding is neither OK nor a fault
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SADR = 3'd2;
   localparam logic [2:0] SINS = 3'd3;
   localparam logic [2:0] SHLT = 3'd4;

   // Branch / conditional-move function codes
   localparam logic [3:0] C_ALL = 4'd0;
   localparam logic [3:0] C_LE  = 4'd1;
   localparam logic [3:0] C_L   = 4'd2;
   localparam logic [3:0] C_E   = 4'd3;
   localparam logic [3:0] C_NE  = 4'd4;
   localparam logic [3:0] C_GE  = 4'd5;
   localparam logic [3:0] C_G   = 4'd6;

   // Condition-code bit positions inside {ZF,SF,OF}
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [2:0] CC_RESET = 3'b100;

   // A status that stops the machine and freezes the condition codes
   function automatic logic is_fault(input logic [2:0] stat);
      return (stat == SADR) || (stat == SINS) || (stat == SHLT);
   endfunction

endpackage

// File: rtl/exec_cc_controller_cond_eval.sv
// Pure combinational evaluation of a branch/cmov condition from stored CC.
module cond_eval
   import exec_cc_controller_pkg::*;
(
   input  logic [2:0] cc,
   input  logic [3:0] ifun,
   output logic       cnd
);

   logic zf;
   logic sf;
   logic of;

   assign zf = cc[CC_ZF];
   assign sf = cc[CC_SF];
   assign of = cc[CC_OF];

   // Decode the function code into the matching flag expression
   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_ALL:   cnd = 1'b1;
         C_LE:    cnd = (sf ^ of) | zf;
         C_L:     cnd = sf ^ of;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~(sf ^ of);
         C_G:     cnd = ~(sf ^ of) & ~zf;
         default: cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_cc_controller.sv
// Execute-stage condition-code register with exception freeze and a
// saturating count of CC updates.
module exec_cc_controller
   import exec_cc_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_ifun,
   input  logic        E_valid,
   input  logic [2:0]  alu_cc,
   input  logic [2:0]  m_stat,
   input  logic [2:0]  W_stat,
   output logic [2:0]  cc,
   output logic        e_Cnd,
   output logic        frozen,
   output logic [15:0] upd_cnt
);

   typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

   state_t state;
   state_t state_nxt;
   logic   set_cc;
   logic   freeze_evt;
   logic   cnd;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Only a real OPq with both downstream stages healthy may touch CC
   assign set_cc = E_valid && (E_icode == IOPQ) && (m_stat == SAOK) &&
                   (W_stat == SAOK) && (state == RUN);

   assign freeze_evt = is_fault(m_stat) || is_fault(W_stat);

   assign frozen = (state == FROZEN);

   // State register; FROZEN is only left through reset
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (freeze_evt) state_nxt = FROZEN;
         FROZEN:  state_nxt = FROZEN;
         default: state_nxt = RUN;
      endcase
   end

   // Condition codes and update counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cc      <= CC_RESET;
         upd_cnt <= 16'd0;
      end else if (set_cc) begin
         cc      <= alu_cc;
         upd_cnt <= sat_inc(upd_cnt);
      end
   end

   cond_eval u_cond_eval (
      .cc   (cc),
      .ifun (E_ifun),
      .cnd  (cnd)
   );

   assign e_Cnd = E_valid & cnd;

endmodule

// File: tb/tb_exec_cc_controller.sv
// Directed bench for exec_cc_controller: reset, CC load, conditions,
// freeze behaviour, reset priority and counter saturation.
module tb_exec_cc_controller;
   import exec_cc_controller_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  E_icode;
   logic [3:0]  E_ifun;
   logic        E_valid;
   logic [2:0]  alu_cc;
   logic [2:0]  m_stat;
   logic [2:0]  W_stat;
   logic [2:0]  cc;
   logic        e_Cnd;
   logic        frozen;
   logic [15:0] upd_cnt;

   int errors = 0;
   int checks = 0;

   exec_cc_controller dut (
      .clk     (clk),
      .rst     (rst),
      .E_icode (E_icode),
      .E_ifun  (E_ifun),
      .E_valid (E_valid),
      .alu_cc  (alu_cc),
      .m_stat  (m_stat),
      .W_stat  (W_stat),
      .cc      (cc),
      .e_Cnd   (e_Cnd),
      .frozen  (frozen),
      .upd_cnt (upd_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected e_Cnd for cc=3'b010 (ZF=0,SF=1,OF=0), ifun 0..7
   logic exp_cnd_010 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      rst = 1'b1; E_icode = INOP; E_ifun = 4'd0; E_valid = 1'b0;
      alu_cc = 3'b000; m_stat = SAOK; W_stat = SAOK;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("reset_cc", {13'd0, cc}, 16'h0004);
      check("reset_frozen", {15'd0, frozen}, 16'd0);
      check("reset_cnt", upd_cnt, 16'd0);
      E_valid = 1'b1; E_icode = INOP; E_ifun = C_E;
      #1 check("reset_cnd_e", {15'd0, e_Cnd}, 16'd1);

      // First OPq update
      E_icode = IOPQ; alu_cc = 3'b010;
      tick();
      E_icode = INOP;
      check("load_cc", {13'd0, cc}, 16'h0002);
      check("load_cnt", upd_cnt, 16'd1);
      for (int i = 0; i < 8; i++) begin
         E_ifun = 4'(i);
         #1 check($sformatf("cnd_ifun%0d", i), {15'd0, e_Cnd}, {15'd0, exp_cnd_010[i]});
      end
      E_ifun = 4'd9;
      #1 check("cnd_ifun9", {15'd0, e_Cnd}, 16'd0);

      // Bubble: no update, condition forced low
      E_valid = 1'b0; E_icode = IOPQ; E_ifun = C_ALL; alu_cc = 3'b111;
      #1 check("bubble_cnd", {15'd0, e_Cnd}, 16'd0);
      tick();
      check("bubble_cc", {13'd0, cc}, 16'h0002);
      check("bubble_cnt", upd_cnt, 16'd1);

      // Non-OK, non-fault status blocks update without freezing
      E_valid = 1'b1; m_stat = 3'd5;
      tick();
      m_stat = SAOK; W_stat = 3'd0;
      tick();
      W_stat = SAOK;
      check("oddstat_cc", {13'd0, cc}, 16'h0002);
      check("oddstat_frozen", {15'd0, frozen}, 16'd0);
      check("oddstat_cnt", upd_cnt, 16'd1);

      // Fault in memory stage alongside an OPq
      alu_cc = 3'b001; m_stat = SADR;
      #1 check("prefreeze_frozen", {15'd0, frozen}, 16'd0);
      tick();
      check("freeze_cc", {13'd0, cc}, 16'h0002);
      check("freeze_frozen", {15'd0, frozen}, 16'd1);
      m_stat = SAOK;
      tick();
      check("frozen_cc", {13'd0, cc}, 16'h0002);
      check("frozen_cnt", upd_cnt, 16'd1);
      check("frozen_stay", {15'd0, frozen}, 16'd1);

      // Reset while frozen, with an OPq present: reset wins
      rst = 1'b1; alu_cc = 3'b000;
      tick();
      rst = 1'b0;
      check("rstfrz_cc", {13'd0, cc}, 16'h0004);
      check("rstfrz_frozen", {15'd0, frozen}, 16'd0);
      check("rstfrz_cnt", upd_cnt, 16'd0);
      tick();
      check("resume_cc", {13'd0, cc}, 16'h0000);
      check("resume_cnt", upd_cnt, 16'd1);

      // Halt in writeback freezes too
      E_icode = INOP; W_stat = SHLT;
      tick();
      W_stat = SAOK;
      check("whlt_frozen", {15'd0, frozen}, 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Counter saturation
      E_icode = IOPQ; alu_cc = 3'b011;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      check("sat_fffe", upd_cnt, 16'hFFFE);
      tick();
      check("sat_ffff", upd_cnt, 16'hFFFF);
      alu_cc = 3'b110;
      tick();
      check("sat_hold", upd_cnt, 16'hFFFF);
      check("sat_cc_load", {13'd0, cc}, 16'h0006);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exec_cc_controller.md
EXEC_CC_CONTROLLER -- requirements
Module: exec_cc_controller

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port E_icode, input, 4, instruction code in execute stage.
REQ-004 SHALL have port E_ifun, input, 4, function code in execute stage.
REQ-005 SHALL have port E_valid, input, 1, execute stage holds a real instruction; 0 means bubble.
REQ-006 SHALL have port alu_cc, input, 3, ALU condition codes {ZF,SF,OF}, bit2=ZF, bit1=SF, bit0=OF.
REQ-007 SHALL have port m_stat, input, 3, status of the instruction in memory stage.
REQ-008 SHALL have port W_stat, input, 3, status of the instruction in writeback stage.
REQ-009 SHALL have port cc, output, 3, registered condition codes, same bit order as alu_cc.
REQ-010 SHALL have port e_Cnd, output, 1, combinational branch/cmov condition from cc and E_ifun.
REQ-011 SHALL have port frozen, output, 1, registered; 1 once an exception has frozen CC.
REQ-012 SHALL have port upd_cnt, output, 16, registered count of CC updates, saturating.

Function
REQ-013 SHALL set set_cc = E_valid AND E_icode==IOPQ(4'h6) AND m_stat in {SAOK} AND W_stat in {SAOK} AND state==RUN.
REQ-014 SHALL load cc <= alu_cc on the rising edge where set_cc=1; cc SHALL hold otherwise; one-cycle latency.
REQ-015 SHALL implement two states: RUN and FROZEN.
REQ-016 RUN->FROZEN SHALL occur on the edge where m_stat or W_stat is SADR(2), SINS(3) or SHLT(4); FROZEN SHALL persist until rst.
REQ-017 On the freezing edge, cc SHALL NOT update even if E_icode==IOPQ; frozen SHALL be 1 from the next cycle.
REQ-018 m_stat/W_stat values 0,5,6,7 SHALL be treated as non-SAOK for set_cc and SHALL NOT cause freezing.
REQ-019 e_Cnd SHALL use registered cc (not alu_cc): ifun 0 always=1; 1 LE=(SF^OF)|ZF; 2 L=SF^OF; 3 E=ZF; 4 NE=~ZF; 5 GE=~(SF^OF); 6 G=~(SF^OF)&~ZF; 7..15 =0.
REQ-020 e_Cnd SHALL be forced 0 when E_valid=0.
REQ-021 upd_cnt SHALL increment by 1 on every edge where set_cc=1 and SHALL saturate at 16'hFFFF (no wrap).
REQ-022 Simultaneous set_cc and rst: rst SHALL win.

Reset
REQ-023 On rst: cc SHALL be 3'b100 (ZF=1,SF=0,OF=0), state RUN, frozen 0, upd_cnt 0.
REQ-024 rst asserted mid-FROZEN SHALL return to RUN on that edge; updates resume the following cycle.

Structure
REQ-025 Shared package SHALL hold icode constants (IOPQ etc.), stat codes (SAOK=1,SADR=2,SINS=3,SHLT=4), ifun condition codes 0..6 and the CC bit-index constants.
REQ-026 Condition evaluation SHALL be one combinational sub-module cond_eval (inputs cc, ifun; output cnd); state/counters SHALL live in the top.

Verification
REQ-027 rst, then idle -> cc=3'b100, frozen=0, upd_cnt=0, e_Cnd with ifun=3 =1.
REQ-028 E_valid=1, E_icode=6, alu_cc=3'b010, stats SAOK -> next cycle cc=3'b010, upd_cnt=1; ifun=2 gives e_Cnd=1, ifun=6 gives 0.
REQ-029 E_icode=6, alu_cc=3'b001, m_stat=SADR same cycle -> cc unchanged, frozen=1 next cycle; later SAOK IOPQ still no update.
REQ-030 FROZEN then rst for one cycle -> cc=3'b100, frozen=0; following IOPQ with alu_cc=3'b000 loads cc=3'b000.
REQ-031 Force upd_cnt to 16'hFFFE via 65534 updates (or backdoor), two more updates -> 16'hFFFF, holds.
REQ-032 E_valid=0 with E_icode=6 -> no cc update, e_Cnd=0 for ifun=0.
